// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS CPU pipeline: word width, fetch constants
// and the fetch-queue entry type that carries {pc, instruction} to decode.
package cpu_defs;

    localparam int WORD_WIDTH = 32;

    // Bubble instruction; also the reset contents of the fetch queue slots.
    localparam logic [WORD_WIDTH-1:0] INSTRUCTION_NOP = 32'h0000_0000;

    // Byte distance between consecutive sequential fetches.
    localparam logic [WORD_WIDTH-1:0] PC_INCREMENT = 32'd4;

    // Low address bits that must be zero for a word-aligned fetch address.
    localparam logic [WORD_WIDTH-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instruction;
    } fetch_entry_t;

    // True when a byte address points at the start of a 32-bit word.
    function automatic logic isWordAligned(input logic [WORD_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instructions sitting between the ROM response and
// the decode stage. Slot 0 is always the head, so the decode-facing outputs
// come straight from registers. Push and pop in the same cycle are both
// honoured; flush empties the queue and takes priority over everything else.
module fetch_buffer
    import cpu_defs::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [WORD_WIDTH-1:0] i_pushPc,
    input  logic [WORD_WIDTH-1:0] i_pushInstruction,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [WORD_WIDTH-1:0] o_headPc,
    output logic [WORD_WIDTH-1:0] o_headInstruction,
    output logic [1:0]            o_count
);

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;

    fetch_entry_t w_newEntry;
    logic         w_popOk;
    logic         w_pushOk;

    assign w_newEntry = '{pc: i_pushPc, instruction: i_pushInstruction};

    // A pop on an empty queue, or a push on a full queue without a matching
    // pop, would corrupt the count; the issue logic upstream never asks for
    // either, but the guards keep the FIFO self-consistent regardless.
    assign w_popOk  = i_pop && (r_count != 2'd0);
    assign w_pushOk = i_push && ((r_count != 2'd2) || w_popOk);

    // Queue storage and occupancy: slot 0 is the head, slot 1 the entry behind it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot0 <= '{pc: '0, instruction: INSTRUCTION_NOP};
            r_slot1 <= '{pc: '0, instruction: INSTRUCTION_NOP};
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_pushOk, w_popOk})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= w_newEntry;
                    end else begin
                        r_slot1 <= w_newEntry;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= w_newEntry;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_newEntry;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_valid           = (r_count != 2'd0);
    assign o_headPc          = r_slot0.pc;
    assign o_headInstruction = r_slot0.instruction;
    assign o_count           = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Owns the program counter, issues word reads to
// the instruction ROM (one-cycle read latency), buffers returned words in a
// 2-entry queue and presents {pc, instruction} to decode over valid/ready.
// A redirect flushes everything younger than the current pop and restarts
// fetch at the new target.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   - a misaligned redirect halts fetch and raises fetch_exception
//               with the offending target on exception_pc until the next
//               aligned redirect.
//   undefined - the low two target bits are forced to zero and the exception
//               outputs are tied low.
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                    BUFFER_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  rom_enable,
    output logic [WORD_WIDTH-1:0] rom_address,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic                  decode_valid,
    input  logic                  decode_ready,
    output logic [WORD_WIDTH-1:0] decode_pc,
    output logic [WORD_WIDTH-1:0] decode_instruction,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_target,
    output logic                  fetch_exception,
    output logic [WORD_WIDTH-1:0] exception_pc
);

    // The queue is built with exactly two slots; BUFFER_DEPTH only sets the
    // occupancy limit the issue logic works against and must stay at 2.
    localparam logic [2:0] QUEUE_LIMIT = 3'(BUFFER_DEPTH);

    logic [WORD_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [WORD_WIDTH-1:0] r_inflightPc;

    logic [WORD_WIDTH-1:0] w_target;
    logic                  w_halted;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [1:0]            w_count;
    logic [2:0]            w_occupancy;

    // Handshake with decode. The head is registered inside the buffer.
    assign w_pop = decode_valid && decode_ready;

    // Slots that will be spoken for at the end of this cycle: what is queued,
    // plus the word coming back from the ROM, minus what decode takes now.
    // Issuing only while this is below the limit guarantees the response of
    // a new request always finds a free slot.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // A redirect kills this cycle's request; reset holds the ROM port quiet.
    assign w_issue = !reset && !redirect_valid && !w_halted && (w_occupancy < QUEUE_LIMIT);

    assign rom_enable  = w_issue;
    assign rom_address = r_pc;

    // A returning word is dropped if a redirect lands in the same cycle,
    // because it belongs to the path being abandoned.
    assign w_push = r_inflight && !redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic                  r_halted;
    logic [WORD_WIDTH-1:0] r_exceptionPc;

    assign w_target = redirect_target;

    // Track the exception state: every redirect re-evaluates alignment, so a
    // misaligned one halts fetch and the next aligned one resumes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_halted      <= 1'b0;
            r_exceptionPc <= '0;
        end else if (redirect_valid) begin
            r_halted <= !isWordAligned(redirect_target);
            if (!isWordAligned(redirect_target)) begin
                r_exceptionPc <= redirect_target;
            end
        end
    end

    assign w_halted        = r_halted;
    assign fetch_exception = r_halted;
    assign exception_pc    = r_exceptionPc;
`else
    assign w_target        = redirect_target & WORD_ALIGN_MASK;
    assign w_halted        = 1'b0;
    assign fetch_exception = 1'b0;
    assign exception_pc    = '0;
`endif

    // Program counter and the record of the request awaiting its ROM word.
    // The PC wraps naturally modulo 2^32 at the top of the address space.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_inflight   <= 1'b0;
            r_inflightPc <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_INCREMENT;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflightPc <= r_pc;
            end
        end
    end

    fetch_buffer u_fetchBuffer (
        .clock             (clock),
        .reset             (reset),
        .i_push            (w_push),
        .i_pushPc          (r_inflightPc),
        .i_pushInstruction (rom_data),
        .i_pop             (w_pop),
        .i_flush           (redirect_valid),
        .o_valid           (decode_valid),
        .o_headPc          (decode_pc),
        .o_headInstruction (decode_instruction),
        .o_count           (w_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. A behavioural ROM returns 32'h1000_0000 + word
// index one cycle after each request. Scenarios push the instructions they
// expect decode to see into a scoreboard queue; a monitor pops and compares
// on every decode handshake. Scenario tasks also check timing inline.
`timescale 1ns/1ps
module tb_fetch_stage;
    import cpu_defs::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rom_enable;
    logic [31:0] rom_address;
    logic [31:0] rom_data = 32'h0;
    logic        decode_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] decode_pc;
    logic [31:0] decode_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        fetch_exception;
    logic [31:0] exception_pc;

    int assertCount = 0;
    int failCount   = 0;

    fetch_entry_t expQ[$];
    fetch_entry_t monEntry;

    fetch_stage #(
        .RESET_PC     (RESET_PC),
        .BUFFER_DEPTH (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .rom_enable         (rom_enable),
        .rom_address        (rom_address),
        .rom_data           (rom_data),
        .decode_valid       (decode_valid),
        .decode_ready       (decode_ready),
        .decode_pc          (decode_pc),
        .decode_instruction (decode_instruction),
        .redirect_valid     (redirect_valid),
        .redirect_target    (redirect_target),
        .fetch_exception    (fetch_exception),
        .exception_pc       (exception_pc)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    function automatic logic [31:0] romWord(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Instruction ROM model: one-cycle read latency, garbage when not enabled.
    always @(posedge clock) begin
        rom_data <= rom_enable ? romWord(rom_address) : 32'hBAD0_0000;
    end

    // Scoreboard monitor: every decode handshake must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && decode_valid && decode_ready) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_pop: got pc=%h instr=%h, required no handshake", decode_pc, decode_instruction);
            end else begin
                monEntry = expQ.pop_front();
                assertCount++;
                if (decode_pc !== monEntry.pc) begin
                    failCount++;
                    $display("[TB] FAIL sb_pc: got %h, required %h", decode_pc, monEntry.pc);
                end
                assertCount++;
                if (decode_instruction !== monEntry.instruction) begin
                    failCount++;
                    $display("[TB] FAIL sb_instr: got %h, required %h", decode_instruction, monEntry.instruction);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] startPc, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back('{pc: startPc + 32'(4 * i), instruction: romWord(startPc + 32'(4 * i))});
        end
    endtask

    task automatic waitDrain(input int budget, output int cycles);
        cycles = 0;
        while (expQ.size() != 0 && cycles < budget) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    // Leaves the bench just after a rising edge with reset already released.
    task automatic doReset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        decode_ready = 1'b0;
        expQ.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clock);
        #1;
        assertCount++;
        if (decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_valid: got %b, required 0", decode_valid); end
        assertCount++;
        if (rom_enable !== 1'b0) begin failCount++; $display("[TB] FAIL rst_rom_enable: got %b, required 0", rom_enable); end
        assertCount++;
        if (rom_address !== RESET_PC) begin failCount++; $display("[TB] FAIL rst_rom_address: got %h, required %h", rom_address, RESET_PC); end
        assertCount++;
        if (decode_pc !== 32'h0) begin failCount++; $display("[TB] FAIL rst_decode_pc: got %h, required 0", decode_pc); end
        assertCount++;
        if (decode_instruction !== 32'h0) begin failCount++; $display("[TB] FAIL rst_decode_instr: got %h, required 0", decode_instruction); end
        assertCount++;
        if (fetch_exception !== 1'b0) begin failCount++; $display("[TB] FAIL rst_exception: got %b, required 0", fetch_exception); end
        assertCount++;
        if (exception_pc !== 32'h0) begin failCount++; $display("[TB] FAIL rst_exception_pc: got %h, required 0", exception_pc); end
    endtask

    task automatic test_startup();
        int cycles;
        doReset();
        decode_ready = 1'b1;
        applyStimulus(RESET_PC, 8);
        @(negedge clock);
        assertCount++;
        if (rom_enable !== 1'b1) begin failCount++; $display("[TB] FAIL start_first_req: got %b, required 1", rom_enable); end
        assertCount++;
        if (decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL start_valid_c0: got %b, required 0", decode_valid); end
        @(negedge clock);
        assertCount++;
        if (decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL start_valid_c1: got %b, required 0", decode_valid); end
        assertCount++;
        if (rom_address !== RESET_PC + 32'd4) begin failCount++; $display("[TB] FAIL start_addr_c1: got %h, required %h", rom_address, RESET_PC + 32'd4); end
        @(negedge clock);
        assertCount++;
        if (decode_valid !== 1'b1) begin failCount++; $display("[TB] FAIL start_valid_c2: got %b, required 1", decode_valid); end
        waitDrain(40, cycles);
        decode_ready = 1'b0;
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL start_drain: got %0d left, required 0", expQ.size()); end
        assertCount++;
        if (cycles != 8) begin failCount++; $display("[TB] FAIL start_throughput: got %0d cycles, required 8", cycles); end
    endtask

    task automatic test_backpressure();
        int cycles;
        doReset();
        decode_ready = 1'b1;
        applyStimulus(RESET_PC, 12);
        repeat (5) @(posedge clock);
        #1;
        decode_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            assertCount++;
            if (rom_enable !== 1'b0) begin failCount++; $display("[TB] FAIL bp_rom_enable[%0d]: got %b, required 0", i, rom_enable); end
            assertCount++;
            if (decode_valid !== 1'b1) begin failCount++; $display("[TB] FAIL bp_valid[%0d]: got %b, required 1", i, decode_valid); end
            assertCount++;
            if (decode_pc !== 32'hC) begin failCount++; $display("[TB] FAIL bp_head_held[%0d]: got %h, required 0000000c", i, decode_pc); end
        end
        @(posedge clock);
        #1;
        decode_ready = 1'b1;
        waitDrain(60, cycles);
        decode_ready = 1'b0;
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL bp_drain: got %0d left, required 0", expQ.size()); end
    endtask

    task automatic test_redirect();
        int cycles;
        doReset();
        decode_ready = 1'b1;
        applyStimulus(RESET_PC, 16);
        repeat (6) @(posedge clock);
        #1;
        decode_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        expQ.delete();
        applyStimulus(32'h40, 6);
        @(negedge clock);
        assertCount++;
        if (rom_enable !== 1'b0) begin failCount++; $display("[TB] FAIL redir_no_req: got %b, required 0", rom_enable); end
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        decode_ready = 1'b1;
        @(negedge clock);
        assertCount++;
        if (decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL redir_valid_t1: got %b, required 0", decode_valid); end
        assertCount++;
        if (rom_enable !== 1'b1 || rom_address !== 32'h40) begin failCount++; $display("[TB] FAIL redir_req_t1: got en=%b addr=%h, required en=1 addr=00000040", rom_enable, rom_address); end
        @(negedge clock);
        assertCount++;
        if (decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL redir_valid_t2: got %b, required 0", decode_valid); end
        @(negedge clock);
        assertCount++;
        if (decode_valid !== 1'b1 || decode_pc !== 32'h40) begin failCount++; $display("[TB] FAIL redir_head_t3: got valid=%b pc=%h, required valid=1 pc=00000040", decode_valid, decode_pc); end
        waitDrain(40, cycles);
        decode_ready = 1'b0;
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL redir_drain: got %0d left, required 0", expQ.size()); end
    endtask

    task automatic test_async_reset();
        int cycles;
        doReset();
        decode_ready = 1'b1;
        applyStimulus(RESET_PC, 16);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b1;
        expQ.delete();
        #1;
        assertCount++;
        if (decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL arst_valid: got %b, required 0", decode_valid); end
        assertCount++;
        if (rom_enable !== 1'b0) begin failCount++; $display("[TB] FAIL arst_rom_enable: got %b, required 0", rom_enable); end
        assertCount++;
        if (rom_address !== RESET_PC) begin failCount++; $display("[TB] FAIL arst_rom_address: got %h, required %h", rom_address, RESET_PC); end
        assertCount++;
        if (decode_pc !== 32'h0 || decode_instruction !== 32'h0) begin failCount++; $display("[TB] FAIL arst_head: got pc=%h instr=%h, required 0/0", decode_pc, decode_instruction); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(RESET_PC, 6);
        waitDrain(40, cycles);
        decode_ready = 1'b0;
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL arst_drain: got %0d left, required 0", expQ.size()); end
    endtask

    task automatic test_wrap();
        int cycles;
        doReset();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        applyStimulus(32'hFFFF_FFFC, 3);
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        decode_ready = 1'b1;
        waitDrain(40, cycles);
        decode_ready = 1'b0;
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL wrap_drain: got %0d left, required 0", expQ.size()); end
    endtask

    task automatic test_misaligned();
        int cycles;
        doReset();
        redirect_valid = 1'b1;
        redirect_target = 32'h42;
`ifdef FETCH_ALIGN_CHECK_EN
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        decode_ready = 1'b1;
        @(negedge clock);
        assertCount++;
        if (fetch_exception !== 1'b1) begin failCount++; $display("[TB] FAIL mis_exception: got %b, required 1", fetch_exception); end
        assertCount++;
        if (exception_pc !== 32'h42) begin failCount++; $display("[TB] FAIL mis_exception_pc: got %h, required 00000042", exception_pc); end
        for (int i = 0; i < 4; i++) begin
            assertCount++;
            if (rom_enable !== 1'b0 || decode_valid !== 1'b0) begin failCount++; $display("[TB] FAIL mis_halted[%0d]: got en=%b valid=%b, required 0/0", i, rom_enable, decode_valid); end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        applyStimulus(32'h80, 4);
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        @(negedge clock);
        assertCount++;
        if (fetch_exception !== 1'b0) begin failCount++; $display("[TB] FAIL mis_clear: got %b, required 0", fetch_exception); end
        assertCount++;
        if (rom_enable !== 1'b1 || rom_address !== 32'h80) begin failCount++; $display("[TB] FAIL mis_resume: got en=%b addr=%h, required en=1 addr=00000080", rom_enable, rom_address); end
`else
        applyStimulus(32'h40, 4);
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        decode_ready = 1'b1;
        @(negedge clock);
        assertCount++;
        if (rom_address !== 32'h40) begin failCount++; $display("[TB] FAIL mis_forced_align: got %h, required 00000040", rom_address); end
        assertCount++;
        if (fetch_exception !== 1'b0 || exception_pc !== 32'h0) begin failCount++; $display("[TB] FAIL mis_no_exception: got exc=%b pc=%h, required 0/0", fetch_exception, exception_pc); end
`endif
        waitDrain(40, cycles);
        decode_ready = 1'b0;
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL mis_drain: got %0d left, required 0", expQ.size()); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        $display("[TB] fetch_stage bench starting");
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_async_reset();
        test_wrap();
        test_misaligned();
        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the MIPS CPU inside the SOPC. It owns the program counter, issues word reads to the instruction ROM (one-cycle read latency), and buffers the returned words in a 2-entry queue. It then presents `{pc, instruction}` to the decode stage over a valid/ready handshake. Branch and jump redirects from the pipeline flush the queue and restart fetch at the new target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUFFER_DEPTH`, default 2: queue entries. Fixed at 2; any other value is unsupported.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `rom_enable` out 1: read request this cycle.
- `rom_address` out 32: byte address of the request; equals the PC register.
- `rom_data` in 32: read data, valid one cycle after an accepted request.
- `decode_valid` out 1: queue head holds a valid instruction.
- `decode_ready` in 1: decode accepts the head this cycle.
- `decode_pc` out 32: PC of the head entry.
- `decode_instruction` out 32: instruction word of the head entry.
- `redirect_valid` in 1: control-flow change this cycle.
- `redirect_target` in 32: new fetch byte address.
- `fetch_exception` out 1: misaligned redirect target. Tied 0 unless `FETCH_ALIGN_CHECK_EN` is defined.
- `exception_pc` out 32: offending target. Tied 0 unless `FETCH_ALIGN_CHECK_EN` is defined.

## Operation
- State:
  - `pc` (32 bits).
  - Queue `count` (0..2).
  - `inflight` bit.
  - Queue storage of 2 × {pc, instruction}.
- `pop` = `decode_valid && decode_ready`.
- Issue condition: `!redirect_valid && !halted && (count + inflight - pop) < 2`.
  - When the condition holds: `rom_enable=1`, `pc <= pc + 4`, `inflight <= 1`.
  - Otherwise: `inflight <= 0`.
- Response: when `inflight` is 1 in cycle t, `rom_data` in t is written to the queue tail with the PC issued in t-1. The write is skipped if `redirect_valid` is 1 in t.
- Queue is FIFO. Push and pop in the same cycle are both honoured. Count never exceeds 2, and the issue rule guarantees a push never hits a full queue.
- Redirect in cycle t:
  - A pop in t still completes; delay-slot handling belongs downstream.
  - All remaining queue entries are flushed.
  - The response arriving in t is dropped and no request is issued in t.
  - `pc <= redirect_target`.
- Simultaneous redirect and push: redirect wins and the queue ends empty.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset, including mid-operation:
  - `pc=RESET_PC`, `count=0`, `inflight=0`, `halted=0`.
  - All outputs 0, except `rom_address=RESET_PC`.
  - An in-flight ROM word is ignored.

## Timing
- Reset deassert at edge e: first request is issued in the cycle after e; `decode_valid` rises 2 cycles later.
- Fetch-to-decode latency is 2 cycles: request in t, data in t+1, visible at the queue head in t+2.
- Throughput is 1 instruction per cycle with `decode_ready` held at 1 (steady state `count=1`, `inflight=1`).
- Redirect in t:
  - `decode_valid=0` in t+1.
  - First new request in t+1.
  - Target instruction at decode in t+3.
- `decode_ready` low: the queue fills to 2 and issue stops. Head outputs stay stable while `decode_valid && !decode_ready`.
- Outputs are registered (queue head) except `rom_enable` and `rom_address`, which are combinational from state plus `redirect_valid`/`decode_ready`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `target[1:0] != 0` sets `halted=1`, `fetch_exception=1` and `exception_pc=target` from the next cycle.
  - While halted there are no requests and `decode_valid` stays 0.
  - The next aligned redirect clears `halted` and `fetch_exception`.
- `FETCH_ALIGN_CHECK_EN` not defined:
  - `redirect_target[1:0]` is forced to 00.
  - `halted` is constant 0; exception outputs are 0.

## Structure
- Shared package `cpu_defs`:
  - `WORD_WIDTH=32`.
  - `INSTRUCTION_NOP=32'h0000_0000`.
  - `PC_INCREMENT=4`.
  - Typedef `fetch_entry_t` = {pc, instruction}.
- Sub-module `fetch_buffer`: 2-entry FIFO of `fetch_entry_t` with push/pop/flush and count output. The PC, issue logic and alignment check stay in `fetch_stage`.

## Test plan
- Reset release with `RESET_PC=0`, ROM holding word i = 32'h1000_0000+i, `decode_ready=1` → `decode_valid` rises 2 cycles after release; `decode_pc` reads 0, 4, 8, … on consecutive cycles with matching instructions.
- Backpressure: `decode_ready=0` for 5 cycles mid-stream → count saturates at 2, `rom_enable=0`, head held; on release, no instruction is lost or duplicated.
- Redirect to 32'h40 while the queue holds 2 entries and one request is in flight → next `decode_valid` is at t+3 with `decode_pc=32'h40`; none of the stale PCs appear.
- Async reset asserted mid-stream, between clock edges → all outputs clear immediately; after release, fetch restarts at `RESET_PC`.
- With `pc` at 32'hFFFF_FFFC → the next `decode_pc` values are FFFF_FFFC, then 0000_0000.
- With the macro, redirect to 32'h42 → `fetch_exception=1`, `exception_pc=32'h42`, no requests; a later redirect to 32'h80 clears the exception and resumes fetch. Without the macro, the same redirect fetches from 32'h40.
